// File: rtl/fmul_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fmul_pipe                                                  |
// | Purpose  : Three-stage pipelined floating-point multiplier with       |
// |            round-to-nearest-even, overflow saturation to infinity,    |
// |            underflow flush to zero, valid/ready handshake and tag     |
// |            passthrough.                                               |
// | Option   : FMUL_IEEE_SPECIAL_EN - decode all-ones exponent as Inf/NaN |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module fmul_pipe #(
   parameter int EW   = 8,
   parameter int MW   = 23,
   parameter int TAGW = 6
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EW+MW:0]       x1,
   input  logic [EW+MW:0]       x2,
   input  logic [TAGW-1:0]      in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EW+MW:0]       y,
   output logic [TAGW-1:0]      out_tag,
   output logic                 ovf,
   output logic                 unf
);

   localparam int XW  = 1 + EW + MW;
   localparam int PW  = 2 * MW + 2;
   localparam int ESW = EW + 2;
   localparam logic [ESW-1:0] BIAS_E = ESW'((1 << (EW - 1)) - 1);
   localparam logic [ESW-1:0] EMAX_E = ESW'((1 << EW) - 1);

   // ---------------- handshake ----------------
   logic v1, v2;
   logic adv1, adv2, adv3;

   assign adv3     = !out_valid | out_ready;
   assign adv2     = !v2 | adv3;
   assign adv1     = !v1 | adv2;
   assign in_ready = adv1;

   // ---------------- S1 combinational: unpack, multiply, add exponents ----------------
   logic          sa, sb;
   logic [EW-1:0] ea, eb;
   logic [MW-1:0] ma, mb;
   logic          sy_in, zero_in, nan_in, inf_in;
   logic [PW-1:0] prod_in;
   logic [ESW-1:0] esum_in;

   assign {sa, ea, ma} = x1;
   assign {sb, eb, mb} = x2;
   assign sy_in   = sa ^ sb;
   assign zero_in = (ea == '0) | (eb == '0);
   assign prod_in = {{(MW+1){1'b0}}, 1'b1, ma} * {{(MW+1){1'b0}}, 1'b1, mb};
   assign esum_in = {2'b00, ea} + {2'b00, eb};

`ifdef FMUL_IEEE_SPECIAL_EN
   logic a_max, b_max, a_nan, b_nan;
   assign a_max  = &ea;
   assign b_max  = &eb;
   assign a_nan  = a_max & (|ma);
   assign b_nan  = b_max & (|mb);
   // Inf times zero (or denormal, which is treated as zero) is invalid
   assign nan_in = a_nan | b_nan | (a_max & (eb == '0)) | (b_max & (ea == '0));
   assign inf_in = (a_max | b_max) & !nan_in;
`else
   assign nan_in = 1'b0;
   assign inf_in = 1'b0;
`endif

   // ---------------- S1 register ----------------
   logic [TAGW-1:0] tag1;
   logic            sy1, zero1, nan1, inf1;
   logic [PW-1:0]   prod1;
   logic [ESW-1:0]  esum1;

   // Stage 1 captures operands whenever it can advance
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1    <= 1'b0;
         tag1  <= '0;
         sy1   <= 1'b0;
         zero1 <= 1'b0;
         nan1  <= 1'b0;
         inf1  <= 1'b0;
         prod1 <= '0;
         esum1 <= '0;
      end else if (adv1) begin
         v1 <= in_valid;
         if (in_valid) begin
            tag1  <= in_tag;
            sy1   <= sy_in;
            zero1 <= zero_in;
            nan1  <= nan_in;
            inf1  <= inf_in;
            prod1 <= prod_in;
            esum1 <= esum_in;
         end
      end
   end

   // ---------------- S2 combinational: normalise, guard and sticky ----------------
   logic           hi;
   logic [MW-1:0]  mant_n;
   logic           guard_n, sticky_n;
   logic [ESW-1:0] e_n;

   assign hi       = prod1[PW-1];
   assign mant_n   = hi ? prod1[PW-2:MW+1] : prod1[PW-3:MW];
   assign guard_n  = hi ? prod1[MW]        : prod1[MW-1];
   assign sticky_n = hi ? (|prod1[MW-1:0]) : (|prod1[MW-2:0]);
   assign e_n      = esum1 - BIAS_E + {{(ESW-1){1'b0}}, hi};

   // ---------------- S2 register ----------------
   logic [TAGW-1:0] tag2;
   logic            sy2, zero2, nan2, inf2, guard2, sticky2;
   logic [MW-1:0]   mant2;
   logic [ESW-1:0]  e2;

   // Stage 2 holds the normalised mantissa and rounding bits
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v2      <= 1'b0;
         tag2    <= '0;
         sy2     <= 1'b0;
         zero2   <= 1'b0;
         nan2    <= 1'b0;
         inf2    <= 1'b0;
         guard2  <= 1'b0;
         sticky2 <= 1'b0;
         mant2   <= '0;
         e2      <= '0;
      end else if (adv2) begin
         v2 <= v1;
         if (v1) begin
            tag2    <= tag1;
            sy2     <= sy1;
            zero2   <= zero1;
            nan2    <= nan1;
            inf2    <= inf1;
            guard2  <= guard_n;
            sticky2 <= sticky_n;
            mant2   <= mant_n;
            e2      <= e_n;
         end
      end
   end

   // ---------------- S3 combinational: round, range check, pack ----------------
   logic           round_up;
   logic [MW:0]    mant_r;
   logic [ESW-1:0] e_r;
   logic           unf_cond, ovf_cond;
   logic [XW-1:0]  y_n;
   logic           ovf_n, unf_n;

   assign round_up = guard2 & (sticky2 | mant2[0]);
   assign mant_r   = {1'b0, mant2} + {{MW{1'b0}}, round_up};
   // A carry out leaves mant_r[MW-1:0] all zero, so only the exponent moves
   assign e_r      = e2 + {{(ESW-1){1'b0}}, mant_r[MW]};
   assign unf_cond = e_r[ESW-1] | (e_r == '0);
   assign ovf_cond = !e_r[ESW-1] & (e_r >= EMAX_E);

   // Select the packed result; specials take priority over zero and range
   always_comb begin
      y_n   = {sy2, e_r[EW-1:0], mant_r[MW-1:0]};
      ovf_n = 1'b0;
      unf_n = 1'b0;
      if (nan2) begin
         y_n = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      end else if (inf2) begin
         y_n = {sy2, {EW{1'b1}}, {MW{1'b0}}};
      end else if (zero2) begin
         y_n = {sy2, {(EW+MW){1'b0}}};
      end else if (unf_cond) begin
         y_n   = {sy2, {(EW+MW){1'b0}}};
         unf_n = 1'b1;
      end else if (ovf_cond) begin
         y_n   = {sy2, {EW{1'b1}}, {MW{1'b0}}};
         ovf_n = 1'b1;
      end
   end

   // Stage 3 is the output register; it only changes when the consumer can take it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         y         <= '0;
         out_tag   <= '0;
         ovf       <= 1'b0;
         unf       <= 1'b0;
      end else if (adv3) begin
         out_valid <= v2;
         if (v2) begin
            y       <= y_n;
            out_tag <= tag2;
            ovf     <= ovf_n;
            unf     <= unf_n;
         end
      end
   end

endmodule
`default_nettype wire
